serial_magnitude_compare: RTL
=============================

# serial_magnitude_compare

Multi-cycle 32-bit magnitude comparator for the ALU datapath. It accepts two operands through a valid/ready request handshake and scans them MSB-first, one digit per cycle, stopping at the first differing digit. It returns one-hot lt/eq/gt flags through a valid/ready result handshake. It supports unsigned and two's-complement signed comparison, and is the sequential, handshaked counterpart to the combinational less-than path for use where timing or area rules out a flat 32-bit compare.

## Interface
- WIDTH, 32, operand width in bits.
- DIGIT, 4, bits compared per cycle. WIDTH % DIGIT == 0 is required; NDIG = WIDTH/DIGIT (8 by default).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- req_valid  input  1  request operands present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- a  input  WIDTH  operand A; sampled on req_valid && req_ready.
- b  input  WIDTH  operand B; sampled on req_valid && req_ready.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
- res_valid  output  1  result flags valid.
- res_ready  input  1  consumer accepts result.
- lt  output  1  A < B.
- eq  output  1  A == B.
- gt  output  1  A > B.
- busy  output  1  state != IDLE.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: load sa = a ^ (signed_mode << (WIDTH-1)) and sb = b ^ (signed_mode << (WIDTH-1)). Flipping the sign bit maps two's complement to offset binary, so the scan is always unsigned.
  - Clear lt/eq/gt, set digit counter cnt=0, go to SCAN.
- SCAN, each cycle: compare da = sa[WIDTH-1 -: DIGIT] against db = sb[WIDTH-1 -: DIGIT].
  - da < db: lt=1, go to DONE.
  - da > db: gt=1, go to DONE.
  - da == db and cnt == NDIG-1: eq=1, go to DONE.
  - Otherwise: shift sa and sb left by DIGIT, cnt=cnt+1, stay in SCAN.
- DONE:
  - res_valid=1; lt/eq/gt held stable.
  - On res_valid && res_ready: go to IDLE. lt/eq/gt keep their values until the next request is accepted.
- Exactly one of lt/eq/gt is 1 whenever res_valid=1.
- req_valid seen outside IDLE is ignored, and the request is not consumed. The requester must hold a, b and signed_mode stable until req_ready.
- cnt width is clog2(NDIG); it does not wrap because SCAN exits at cnt == NDIG-1.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, res_valid=0, lt=eq=gt=0, busy=0.
  - sa, sb and cnt are cleared to 0.
- Reset mid-SCAN or mid-DONE: IDLE on the next edge. The in-flight result is discarded and res_valid is never asserted for it.
- rst has priority over every handshake in the same cycle.
- Acceptance edge T0: state becomes SCAN and busy=1 after T0.
- Result latency: res_valid rises after edge T0+k, where k = 1 + index of the first differing digit counted from the MSB (k in 1..NDIG). Equal operands give k = NDIG.
- Back-pressure: DONE may last any number of cycles while res_ready=0; flags hold stable throughout.
- res_ready=1 in the first DONE cycle: IDLE after the next edge, so res_valid is high for exactly one cycle.
- Back-to-back operation: minimum request spacing is k+2 cycles (the SCAN cycles, one DONE cycle, one IDLE cycle). A request cannot be accepted in the same cycle a result is consumed.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then a=b=0xFFFFFFFF with signed_mode=0 -> eq=1, lt=gt=0; res_valid after 8 SCAN cycles. Repeat with a=b=0x00000808 -> eq=1, 8 cycles.
- a=0x00000001, b=0x00000002, unsigned -> lt=1 after 8 cycles. Then a=0x00000009, b=0x00000002 -> gt=1 after 8 cycles.
- a=0xFFFFFFFF, b=0x7FFFFFFF: signed_mode=0 -> gt=1; signed_mode=1 -> lt=1 (-1 < 2147483647). Both resolve with k=1.
- a=0xFF98967F, b=0xFB98967F, unsigned -> gt=1 with k=2 (digit 1 differs: 0xF vs 0xB). Hold res_ready=0 for 5 cycles -> res_valid and gt stay stable and req_ready=0; pulse res_ready -> IDLE next edge.
- Assert rst for one edge during cycle 3 of SCAN (a=1, b=2) -> next cycle: IDLE, res_valid=0, flags 0, req_ready=1. A fresh request (a=2, b=1) then completes normally with gt=1.
- Hold req_valid=1 with changing a/b while busy -> the operands are not resampled, and the result matches the operands accepted at T0.

Source files
------------

// File: rtl/serial_magnitude_compare.sv
// serial_magnitude_compare: MSB-first digit-serial lt/eq/gt comparator with request/result handshakes
module serial_magnitude_compare #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic             busy
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CNTW = NDIG > 1 ? $clog2(NDIG) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);
   localparam logic [WIDTH-1:0] SIGN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
   logic [DIGIT-1:0] da, db;

   assign da = sa_q[WIDTH-1 -: DIGIT];
   assign db = sb_q[WIDTH-1 -: DIGIT];
   assign req_ready = state_q == IDLE;
   assign busy = state_q != IDLE;
   assign res_valid = state_q == DONE;
   assign lt = lt_q;
   assign eq = eq_q;
   assign gt = gt_q;

   // next state: load offset-binary operands, scan one digit per cycle, hold result until consumed
   always_comb begin
      state_d = state_q;
      sa_d = sa_q;
      sb_d = sb_q;
      cnt_d = cnt_q;
      lt_d = lt_q;
      eq_d = eq_q;
      gt_d = gt_q;
      case (state_q)
         IDLE: if (req_valid) begin
            sa_d = a ^ (signed_mode ? SIGN : '0);
            sb_d = b ^ (signed_mode ? SIGN : '0);
            cnt_d = '0;
            lt_d = 1'b0;
            eq_d = 1'b0;
            gt_d = 1'b0;
            state_d = SCAN;
         end
         SCAN: if (da < db) begin
            lt_d = 1'b1;
            state_d = DONE;
         end else if (da > db) begin
            gt_d = 1'b1;
            state_d = DONE;
         end else if (cnt_q == LAST) begin
            eq_d = 1'b1;
            state_d = DONE;
         end else begin
            sa_d = sa_q << DIGIT;
            sb_d = sb_q << DIGIT;
            cnt_d = cnt_q + 1'b1;
         end
         DONE: state_d = res_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset discards any in-flight compare
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q <= '0;
         sb_q <= '0;
         cnt_q <= '0;
         lt_q <= 1'b0;
         eq_q <= 1'b0;
         gt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q <= sa_d;
         sb_q <= sb_d;
         cnt_q <= cnt_d;
         lt_q <= lt_d;
         eq_q <= eq_d;
         gt_q <= gt_d;
      end
   end
endmodule
